// File: rtl/branch_predictor_pkg.sv
// Shared pipeline constants for branch prediction: branch opcodes, 2-bit counter
// encodings and the sequential PC increment.
package branch_predictor_pkg;

  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;

  localparam int unsigned PC_INC = 4;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  function automatic logic is_branch_op(input logic [5:0] op);
    return (op == OP_REGIMM) || (op >= OP_BEQ && op <= OP_BGTZ);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter; load forces weakly-taken for a fresh allocation.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       up_i,
  input  logic       load_i,
  output logic [1:0] ctr_o
);

  logic [1:0] ctr_q, ctr_d;

  always_comb begin
    ctr_d = ctr_q;
    if (load_i) begin
      ctr_d = WT;
    end else if (en_i) begin
      if (up_i && ctr_q != ST)       ctr_d = ctr_q + 2'd1;
      else if (!up_i && ctr_q != SNT) ctr_d = ctr_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctr_q <= WNT;
    else        ctr_q <= ctr_d;
  end

  assign ctr_o = ctr_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT/BTB: zero-latency lookup for IF, training and misprediction
// redirect from the ID-stage branch resolution, plus resolution statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      if_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             id_valid,
  input  logic             id_stall,
  input  logic [31:0]      id_pc,
  input  logic             id_branch,
  input  logic [31:0]      id_target,
  input  logic             id_pred_taken,
  input  logic [31:0]      id_pred_target,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [31:0]      target_q [DEPTH];
  logic [1:0]       ctr      [DEPTH];
  logic [DEPTH-1:0] ctr_en, ctr_load;

  logic [IDX_W-1:0] if_idx, id_idx;
  logic [TAG_W-1:0] if_tag, id_tag;
  logic             if_hit, id_hit, upd;
  logic [CNT_W-1:0] branch_cnt_q, mispred_cnt_q;

  // Word-aligned PCs: the low two bits never participate in indexing or tagging.
  wire unused_pc_lsbs = ^{if_pc[1:0], id_pc[1:0]};

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[31:IDX_W+2];
  assign id_idx = id_pc[IDX_W+1:2];
  assign id_tag = id_pc[31:IDX_W+2];

  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = if_hit && ctr[if_idx][1];
  assign pred_target = pred_taken ? target_q[if_idx] : 32'd0;

  assign upd         = id_valid && !id_stall;
  assign id_hit      = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
  assign mispredict  = upd && ((id_branch != id_pred_taken) ||
                               (id_branch && (id_pred_target != id_target)));
  assign redirect_pc = id_branch ? id_target : id_pc + 32'(PC_INC);

  // Hits train the counter either way; only taken misses allocate.
  always_comb begin
    ctr_en   = '0;
    ctr_load = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (upd && id_idx == IDX_W'(i)) begin
        ctr_en[i]   = id_hit;
        ctr_load[i] = !id_hit && id_branch;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ctr
    sat_counter2 u_ctr (
      .clk    (clk),
      .rst_n  (reset),
      .en_i   (ctr_en[g]),
      .up_i   (id_branch),
      .load_i (ctr_load[g]),
      .ctr_o  (ctr[g])
    );
  end

  // Any taken resolution (hit or allocate) writes tag/target; tag is unchanged on a hit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (upd && id_branch) begin
      valid_q[id_idx]  <= 1'b1;
      tag_q[id_idx]    <= id_tag;
      target_q[id_idx] <= id_target;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (upd && branch_cnt_q != '1)        branch_cnt_q  <= branch_cnt_q + CNT_W'(1);
      if (mispredict && mispred_cnt_q != '1) mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: stimulus pushes expectations into a queue,
// a negedge monitor pops and compares them against the live outputs.
module tb_branch_predictor;

  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [31:0]      if_pc = '0;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             id_valid = 1'b0;
  logic             id_stall = 1'b0;
  logic [31:0]      id_pc = '0;
  logic             id_branch = 1'b0;
  logic [31:0]      id_target = '0;
  logic             id_pred_taken = 1'b0;
  logic [31:0]      id_pred_target = '0;
  logic             mispredict;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  branch_predictor #(.IDX_W(4), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .id_valid       (id_valid),
    .id_stall       (id_stall),
    .id_pc          (id_pc),
    .id_branch      (id_branch),
    .id_target      (id_target),
    .id_pred_taken  (id_pred_taken),
    .id_pred_target (id_pred_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef enum int { S_PT, S_PTGT, S_MP, S_RPC, S_BC, S_MC } sig_e;
  typedef struct {
    sig_e        sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic expect_val(input sig_e s, input logic [31:0] v, input string n);
    exp_t e;
    e.sig = s; e.val = v; e.name = n;
    q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic st, input logic [31:0] pc,
                        input logic br, input logic [31:0] tgt,
                        input logic ppt, input logic [31:0] ptgt);
    id_valid = v; id_stall = st; id_pc = pc; id_branch = br;
    id_target = tgt; id_pred_taken = ppt; id_pred_target = ptgt;
  endtask

  // Monitor: all expectations queued this cycle are checked mid-cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.sig)
        S_PT:    act = 32'(pred_taken);
        S_PTGT:  act = pred_target;
        S_MP:    act = 32'(mispredict);
        S_RPC:   act = redirect_pc;
        S_BC:    act = 32'(branch_cnt);
        default: act = 32'(mispred_cnt);
      endcase
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
      end
    end
  end

  initial begin
    // Reset state
    if_pc = 32'h40;
    #1;
    expect_val(S_PT,   0, "rst_pred_taken");
    expect_val(S_PTGT, 0, "rst_pred_target");
    expect_val(S_BC,   0, "rst_branch_cnt");
    expect_val(S_MC,   0, "rst_mispred_cnt");
    expect_val(S_MP,   0, "rst_mispredict");
    expect_val(S_RPC,  32'h4, "rst_redirect_idle");
    next_cycle();
    reset = 1'b1;
    next_cycle();

    // First taken branch at 0x40, predicted not-taken
    set_id(1, 0, 32'h40, 1, 32'h80, 0, 0);
    expect_val(S_MP,  1, "first_mispredict");
    expect_val(S_RPC, 32'h80, "first_redirect");
    expect_val(S_PT,  0, "same_cycle_old_entry");
    next_cycle();
    set_id(0, 0, 0, 0, 0, 0, 0);
    expect_val(S_PT,   1, "alloc_pred_taken");
    expect_val(S_PTGT, 32'h80, "alloc_pred_target");
    expect_val(S_MC,   1, "alloc_mispred_cnt");
    expect_val(S_BC,   1, "alloc_branch_cnt");
    next_cycle();

    // Two correctly predicted taken (ctr 2->3->3)
    set_id(1, 0, 32'h40, 1, 32'h80, 1, 32'h80);
    expect_val(S_MP, 0, "correct_taken_1");
    next_cycle();
    expect_val(S_MP, 0, "correct_taken_2");
    expect_val(S_BC, 2, "branch_cnt_2");
    next_cycle();

    // Not-taken while predicted taken
    set_id(1, 0, 32'h40, 0, 32'h80, 1, 32'h80);
    expect_val(S_MP,  1, "nt_mispredict");
    expect_val(S_RPC, 32'h44, "nt_redirect");
    expect_val(S_MC,  1, "nt_mispred_cnt_pre");
    next_cycle();
    set_id(0, 0, 0, 0, 0, 0, 0);
    expect_val(S_PT,   1, "sat_still_taken");
    expect_val(S_PTGT, 32'h80, "sat_target");
    expect_val(S_MC,   2, "mispred_cnt_2");
    expect_val(S_BC,   4, "branch_cnt_4");
    next_cycle();

    // Aliasing: 0x80 shares index 0 with 0x40
    set_id(1, 0, 32'h80, 1, 32'h100, 0, 0);
    expect_val(S_MP,  1, "alias_mispredict");
    expect_val(S_RPC, 32'h100, "alias_redirect");
    next_cycle();
    set_id(0, 0, 0, 0, 0, 0, 0);
    expect_val(S_PT,   0, "alias_old_miss");
    expect_val(S_PTGT, 0, "alias_old_target");
    expect_val(S_MC,   3, "mispred_cnt_3");
    expect_val(S_BC,   5, "branch_cnt_5");
    next_cycle();
    if_pc = 32'h80;
    expect_val(S_PT,   1, "alias_new_hit");
    expect_val(S_PTGT, 32'h100, "alias_new_target");
    next_cycle();

    // Stall for three cycles, then release
    set_id(1, 1, 32'h204, 1, 32'h300, 0, 0);
    for (int i = 0; i < 3; i++) begin
      expect_val(S_MP, 0, "stall_no_mispredict");
      expect_val(S_BC, 5, "stall_branch_cnt");
      next_cycle();
    end
    id_stall = 1'b0;
    expect_val(S_MP,  1, "unstall_mispredict");
    expect_val(S_RPC, 32'h300, "unstall_redirect");
    next_cycle();
    set_id(0, 0, 0, 0, 0, 0, 0);
    if_pc = 32'h204;
    expect_val(S_BC,   6, "stall_counted_once");
    expect_val(S_MC,   4, "mispred_cnt_4");
    expect_val(S_PT,   1, "stall_alloc_taken");
    expect_val(S_PTGT, 32'h300, "stall_alloc_target");
    next_cycle();

    // id_valid=0 with busy inputs: nothing changes; redirect wraps
    set_id(0, 0, 32'hFFFF_FFFC, 0, 32'h400, 1, 32'h400);
    expect_val(S_MP,  0, "invalid_no_mispredict");
    expect_val(S_RPC, 32'h0, "redirect_wrap");
    next_cycle();
    set_id(0, 0, 32'h208, 1, 32'h400, 0, 0);
    next_cycle();
    set_id(0, 0, 0, 0, 0, 0, 0);
    if_pc = 32'h208;
    expect_val(S_PT, 0, "invalid_no_alloc");
    expect_val(S_BC, 6, "invalid_no_count");
    next_cycle();

    // Not-taken miss: counted, not allocated
    set_id(1, 0, 32'h20C, 0, 32'h500, 0, 0);
    expect_val(S_MP,  0, "nt_miss_no_mispredict");
    expect_val(S_RPC, 32'h210, "nt_miss_redirect");
    next_cycle();
    set_id(0, 0, 0, 0, 0, 0, 0);
    if_pc = 32'h20C;
    expect_val(S_PT, 0, "nt_miss_no_alloc");
    expect_val(S_BC, 7, "branch_cnt_7");
    next_cycle();

    // Asynchronous reset mid-stream, checked before any clock edge
    if_pc = 32'h80;
    reset = 1'b0;
    expect_val(S_BC,   0, "async_rst_branch_cnt");
    expect_val(S_MC,   0, "async_rst_mispred_cnt");
    expect_val(S_PT,   0, "async_rst_pred_taken");
    expect_val(S_PTGT, 0, "async_rst_pred_target");
    next_cycle();
    reset = 1'b1;
    if_pc = 32'h204;
    expect_val(S_PT, 0, "post_rst_pred_taken");
    next_cycle();
    next_cycle();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
